overcurrent_monitor: RTL and testbench
======================================

# overcurrent_monitor

Parametrised multi-channel overcurrent protection monitor for the motor-driver current-sense comparators. Each channel's comparator output is synchronised and its high-time accumulated over a fixed measurement window. Any channel at or over threshold trips a shared protection flag and LED for a hold period. Repeated consecutive trips can optionally latch the block into lockout until software clears it.

## Interface
- `N_CH`, 2, number of current-sense channels (≥1)
- `CNT_W`, 32, width of all internal counters
- `WINDOW`, 1_000_000_000, measurement window length in clk cycles (1 ≤ WINDOW < 2^CNT_W)
- `THRESH`, 700_000_000, per-channel high-sample count that trips (1 ≤ THRESH ≤ WINDOW)
- `HOLD_CYCLES`, 200_000_000, cycles `trip` stays asserted after a trip (≥1)
- `MAX_RETRY`, 3, consecutive trips before lockout (≥1; used only with `OCP_LOCKOUT_EN`)
- `clk` in 1: system clock, single clock domain
- `rst` in 1: synchronous, active-high reset
- `sense_in` in N_CH: raw asynchronous comparator outputs, 1 = overcurrent
- `clear` in 1: level; releases lockout
- `trip` out 1: protection flag to the motor enable logic
- `led` out 1: status LED
- `trip_ch` out N_CH: channels that exceeded `THRESH` in the last evaluated window
- `lockout` out 1: latched lockout indicator
- `window_done` out 1: one-cycle pulse per completed window

## Operation
- Reset: `trip`, `led`, `trip_ch`, `lockout`, and `window_done` are 0. State is MEASURE. All counters and sync flops are 0.
- Each `sense_in[i]` passes through 2 flops. The sampled value is `s[i]` = second flop output.
- MEASURE:
  - `win_cnt` counts 0..WINDOW-1.
  - Every cycle, `hi_cnt[i]` += `s[i]`.
  - On the cycle where `win_cnt == WINDOW-1`, that sample is still accumulated. `win_cnt` goes to 0 and the next state is EVAL.
  - `hi_cnt` cannot exceed WINDOW, so no overflow handling is needed.
- EVAL (exactly 1 cycle):
  - `window_done` = 1.
  - `trip_ch[i]` is registered as `hi_cnt[i] >= THRESH`.
  - If any bit is set: `trip` and `led` go to 1, `retry_cnt` increments, next state is HOLD (or LOCKOUT, see Configuration).
  - Otherwise: `retry_cnt` goes to 0 and next state is MEASURE.
  - `hi_cnt` is cleared in both cases.
- HOLD:
  - `hold_cnt` counts 0..HOLD_CYCLES-1.
  - On the last count: `trip`, `led`, and `hold_cnt` go to 0, next state is MEASURE.
  - `trip_ch` holds its value until the next EVAL.
  - `sense_in` is not accumulated. `clear` is ignored.
- LOCKOUT:
  - `trip`, `led`, and `lockout` are held at 1.
  - While `clear` = 1: outputs `trip`, `led`, `lockout`, `trip_ch`, and `retry_cnt` go to 0, and next state is MEASURE with fresh counters.
- `clear` has no effect in MEASURE or EVAL.
- `rst` overrides everything in every state, including mid-window, mid-hold, and with `clear` asserted simultaneously.

## Timing
- A `sense_in` edge affects `hi_cnt` 2 cycles later, after synchronisation.
- Window period from MEASURE entry to the EVAL cycle is WINDOW+1 cycles. The full non-tripping cycle is WINDOW+1.
- `trip` rises on the clock edge ending EVAL and stays high for exactly HOLD_CYCLES cycles.
- After HOLD, the next window begins the cycle `trip` falls.
- `window_done` is high only during EVAL, one pulse per window.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `OCP_LOCKOUT_EN` defined:
  - When EVAL trips and `retry_cnt + 1 == MAX_RETRY`, next state is LOCKOUT instead of HOLD.
  - `lockout` is functional.
- `OCP_LOCKOUT_EN` undefined:
  - LOCKOUT state and `retry_cnt` are not synthesised.
  - Every trip auto-recovers via HOLD.
  - `lockout` is tied to 0.
  - `clear` is unused.

## Test plan
All scenarios use N_CH=2, WINDOW=10, THRESH=7, HOLD_CYCLES=4, MAX_RETRY=2.
- **Below threshold:** ch0 high for 6 of 10 samples → `window_done` pulses, `trip` = 0, `trip_ch` = 00.
- **Single-channel trip:** ch1 high 7 of 10 → `trip`/`led` = 1 for exactly 4 cycles, `trip_ch` = 10, then a new window starts.
- **Lockout path:** both channels held high for 2 consecutive windows with `OCP_LOCKOUT_EN` defined → second EVAL enters LOCKOUT, `lockout` = 1 indefinitely. `clear` = 1 for 1 cycle → all outputs 0 and the window restarts.
- **Non-consecutive trips:** trip, clean window, trip → `retry_cnt` resets on the clean window, no lockout, both trips hold 4 cycles.
- **Reset mid-operation:** `rst` asserted during HOLD (cycle 2) with `clear` = 1 → next cycle all outputs 0, state MEASURE, `win_cnt` = 0.
- **Macro undefined:** continuous overcurrent → `trip` pulses 4 high / 11 low periodically, `lockout` stays 0.

Source files
------------

// File: rtl/overcurrent_monitor.sv
// Multi-channel overcurrent monitor: per-window high-time accumulation, shared trip/hold.
// Optional consecutive-trip lockout enabled by defining OCP_LOCKOUT_EN.
module overcurrent_monitor #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WINDOW      = 1_000_000_000,
  parameter int unsigned THRESH      = 700_000_000,
  parameter int unsigned HOLD_CYCLES = 200_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sense_in,
  input  logic            clear,
  output logic            trip,
  output logic            led,
  output logic [N_CH-1:0] trip_ch,
  output logic            lockout,
  output logic            window_done
);

  localparam logic [CNT_W-1:0] WinLast  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ThreshC  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StMeasure,
    StEval,
    StHold
`ifdef OCP_LOCKOUT_EN
    , StLockout
`endif
  } state_e;

  state_e            state;
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   s;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  hi_cnt [N_CH];
  logic [N_CH-1:0]   over_thr;

`ifdef OCP_LOCKOUT_EN
  localparam logic [CNT_W-1:0] RetryMax = CNT_W'(MAX_RETRY);
  logic [CNT_W-1:0] retry_cnt;
  logic             lockout_q;
  assign lockout = lockout_q;
`else
  logic unused_cfg;
  assign unused_cfg = clear ^ MAX_RETRY[0];
  assign lockout    = 1'b0;
`endif

  always_comb begin
    over_thr = '0;
    for (int i = 0; i < N_CH; i++) begin
      over_thr[i] = (hi_cnt[i] >= ThreshC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StMeasure;
      sync1       <= '0;
      s           <= '0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      trip        <= 1'b0;
      led         <= 1'b0;
      trip_ch     <= '0;
      window_done <= 1'b0;
      for (int i = 0; i < N_CH; i++) hi_cnt[i] <= '0;
`ifdef OCP_LOCKOUT_EN
      retry_cnt   <= '0;
      lockout_q   <= 1'b0;
`endif
    end else begin
      sync1       <= sense_in;
      s           <= sync1;
      window_done <= 1'b0;
      case (state)
        StMeasure: begin
          for (int i = 0; i < N_CH; i++) hi_cnt[i] <= hi_cnt[i] + CNT_W'(s[i]);
          if (win_cnt == WinLast) begin
            win_cnt     <= '0;
            window_done <= 1'b1;
            state       <= StEval;
          end else begin
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        StEval: begin
          trip_ch <= over_thr;
          for (int i = 0; i < N_CH; i++) hi_cnt[i] <= '0;
          if (|over_thr) begin
            trip <= 1'b1;
            led  <= 1'b1;
`ifdef OCP_LOCKOUT_EN
            retry_cnt <= retry_cnt + CNT_W'(1);
            if (retry_cnt + CNT_W'(1) == RetryMax) begin
              lockout_q <= 1'b1;
              state     <= StLockout;
            end else begin
              state <= StHold;
            end
`else
            state <= StHold;
`endif
          end else begin
`ifdef OCP_LOCKOUT_EN
            retry_cnt <= '0;
`endif
            state <= StMeasure;
          end
        end
        StHold: begin
          if (hold_cnt == HoldLast) begin
            hold_cnt <= '0;
            trip     <= 1'b0;
            led      <= 1'b0;
            state    <= StMeasure;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
`ifdef OCP_LOCKOUT_EN
        StLockout: begin
          if (clear) begin
            trip      <= 1'b0;
            led       <= 1'b0;
            lockout_q <= 1'b0;
            trip_ch   <= '0;
            retry_cnt <= '0;
            win_cnt   <= '0;
            hold_cnt  <= '0;
            for (int i = 0; i < N_CH; i++) hi_cnt[i] <= '0;
            state     <= StMeasure;
          end else begin
            trip      <= 1'b1;
            led       <= 1'b1;
            lockout_q <= 1'b1;
          end
        end
`endif
        default: state <= StMeasure;
      endcase
    end
  end

endmodule

// File: tb/tb_overcurrent_monitor.sv
// Directed bench for overcurrent_monitor with N_CH=2, WINDOW=10, THRESH=7, HOLD_CYCLES=4,
// MAX_RETRY=2; lockout scenario runs when OCP_LOCKOUT_EN is defined.
module tb_overcurrent_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] sense_in;
  logic       clear;
  logic       trip;
  logic       led;
  logic [1:0] trip_ch;
  logic       lockout;
  logic       window_done;

  int n_checks = 0;
  int n_fails  = 0;
  logic [1:0] last_ch;

  overcurrent_monitor #(
    .N_CH       (2),
    .CNT_W      (32),
    .WINDOW     (10),
    .THRESH     (7),
    .HOLD_CYCLES(4),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sense_in   (sense_in),
    .clear      (clear),
    .trip       (trip),
    .led        (led),
    .trip_ch    (trip_ch),
    .lockout    (lockout),
    .window_done(window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, trip, led, lockout, window_done, trip_ch};
  endfunction

  function automatic logic [7:0] pk(input logic t, input logic l, input logic d,
                                    input logic [1:0] ch);
    return {2'b00, t, t, l, d, ch};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Starts with the FSM freshly in MEASURE; ends after the EVAL edge.
  task automatic run_window(input logic [1:0] mask, input int n, input logic [1:0] exp_ch,
                            input logic exp_lock);
    cyc();
    sense_in = mask;
    repeat (n) cyc();
    sense_in = 2'b00;
    repeat (8 - n) cyc();
    chk("pre_done", outs(), pk(1'b0, 1'b0, 1'b0, last_ch));
    cyc();
    chk("window_done", outs(), pk(1'b0, 1'b0, 1'b1, last_ch));
    cyc();
    last_ch = exp_ch;
    chk("eval", outs(), pk(|exp_ch, exp_lock, 1'b0, exp_ch));
  endtask

  task automatic hold_tail(input logic clr);
    clear = clr;
    repeat (3) begin
      cyc();
      chk("hold_high", outs(), pk(1'b1, 1'b0, 1'b0, last_ch));
    end
    cyc();
    clear = 1'b0;
    chk("hold_end", outs(), pk(1'b0, 1'b0, 1'b0, last_ch));
  endtask

  initial begin
    rst      = 1'b1;
    sense_in = 2'b00;
    clear    = 1'b0;
    last_ch  = 2'b00;
    repeat (3) cyc();
    chk("reset", outs(), pk(1'b0, 1'b0, 1'b0, 2'b00));
    rst = 1'b0;

    // Below threshold, then single-channel trip and the following fresh window
    run_window(2'b01, 6, 2'b00, 1'b0);
    run_window(2'b10, 7, 2'b10, 1'b0);
    hold_tail(1'b0);
    run_window(2'b00, 0, 2'b00, 1'b0);

    // Non-consecutive trips never lock out; clear during HOLD is ignored
    run_window(2'b01, 7, 2'b01, 1'b0);
    hold_tail(1'b0);
    run_window(2'b00, 0, 2'b00, 1'b0);
    run_window(2'b10, 7, 2'b10, 1'b0);
    hold_tail(1'b1);
    run_window(2'b00, 0, 2'b00, 1'b0);

`ifdef OCP_LOCKOUT_EN
    run_window(2'b11, 7, 2'b11, 1'b0);
    hold_tail(1'b0);
    run_window(2'b11, 7, 2'b11, 1'b1);
    repeat (6) begin
      cyc();
      chk("lockout_hold", outs(), pk(1'b1, 1'b1, 1'b0, 2'b11));
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    last_ch = 2'b00;
    chk("lockout_clear", outs(), pk(1'b0, 1'b0, 1'b0, 2'b00));
    run_window(2'b00, 0, 2'b00, 1'b0);
`endif

    // Reset during HOLD with clear asserted
    run_window(2'b11, 7, 2'b11, 1'b0);
    cyc();
    chk("hold_c1", outs(), pk(1'b1, 1'b0, 1'b0, 2'b11));
    rst   = 1'b1;
    clear = 1'b1;
    cyc();
    rst   = 1'b0;
    clear = 1'b0;
    last_ch = 2'b00;
    chk("mid_reset", outs(), pk(1'b0, 1'b0, 1'b0, 2'b00));
    run_window(2'b00, 0, 2'b00, 1'b0);

`ifndef OCP_LOCKOUT_EN
    // Continuous overcurrent: 11 cycles low, 4 high, repeating, never locked
    sense_in = 2'b11;
    for (int k = 1; k <= 45; k++) begin
      cyc();
      chk("continuous", {6'b0, trip, lockout},
          {6'b0, ((k % 15) >= 11) && ((k % 15) <= 14), 1'b0});
    end
    sense_in = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
